// File: rtl/uio_bus_scheduler.sv
// rtl/uio_bus_scheduler.sv - round-robin scheduler sharing the uio pad bus between two requesters
module uio_bus_scheduler #(
  parameter int HOLD_CYCLES   = 2,
  parameter int TURN_CYCLES   = 1,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [1:0]  req,
  input  logic [1:0]  req_we,
  input  logic [15:0] req_wdata,
  output logic [1:0]  ack,
  output logic [7:0]  rdata,
  input  logic [7:0]  uio_in,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, DRIVE, TURN, SAMPLE, DONE} state_t;

  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] TURN_LD   = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] SAMPLE_LD = 4'(SAMPLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       gnt_idx, last_grant;
  logic [7:0] wdata_lat, rdata_r;
  logic       grant, grant_idx, sample_done;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    grant       = 1'b0;
    grant_idx   = 1'b0;
    sample_done = 1'b0;
    case (state)
      IDLE: begin
        if (ena && (req != 2'b00)) begin
          grant     = 1'b1;
          // On a tie the requester that did not win last time goes next
          grant_idx = (req == 2'b11) ? ~last_grant : req[1];
          if (req_we[grant_idx]) begin
            state_nxt = DRIVE;
            cnt_nxt   = HOLD_LD;
          end else begin
            state_nxt = SAMPLE;
            cnt_nxt   = SAMPLE_LD;
          end
        end
      end
      DRIVE: begin
        if (cnt == 4'd0) begin
          state_nxt = TURN;
          cnt_nxt   = TURN_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      TURN: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      SAMPLE: begin
        if (cnt == 4'd0) begin
          state_nxt   = DONE;
          sample_done = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      gnt_idx    <= 1'b0;
      last_grant <= 1'b1;
      wdata_lat  <= 8'h00;
      rdata_r    <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant) begin
        gnt_idx    <= grant_idx;
        last_grant <= grant_idx;
        wdata_lat  <= grant_idx ? req_wdata[15:8] : req_wdata[7:0];
      end
      if (sample_done) rdata_r <= uio_in;
    end
  end

  // Pad controls decode only the state register, so reset clears them without a clock
  assign uio_oe  = (state == DRIVE) ? 8'hFF : 8'h00;
  assign uio_out = (state == DRIVE) ? wdata_lat : 8'h00;
  assign ack     = {(state == DONE) && gnt_idx, (state == DONE) && !gnt_idx};
  assign busy    = (state != IDLE);
  assign rdata   = rdata_r;

endmodule
